io_line_step_sequencer: RTL and testbench

Upstream stage for one ioOutputLine_ControlModule instance. It holds a small table of (delay, duration) steps and plays them back in order. For each step it drives the line controller's onYourMark / GOGOGO_EXCLAMATION / delay / duration inputs, waits for outputComplete, then clears the controller before the next step. Host logic loads the table, then issues start/abort and reads busy/done/step status.

---
 rtl/io_line_step_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_io_line_step_sequencer.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_line_step_sequencer.sv
// Step-table sequencer for one ioOutputLine_ControlModule: plays (delay, duration) steps in order.
// Optional feature macro SEQ_LOOP_EN adds a loop_count input that replays the whole program.
module io_line_step_sequencer #(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int DUR_W = 11,
  parameter int DEL_W = 21
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [DEL_W-1:0] wr_delay,
  input  logic [DUR_W-1:0] wr_duration,
  input  logic [AW:0]      num_steps,
  input  logic             start,
  input  logic             abort,
`ifdef SEQ_LOOP_EN
  input  logic [7:0]       loop_count,
`endif
  output logic             busy,
  output logic             done,
  output logic [AW-1:0]    step_idx,
  output logic             line_mark,
  output logic             line_go,
  output logic [DEL_W-1:0] line_delay,
  output logic [DUR_W-1:0] line_duration,
  output logic             line_rst,
  output logic             line_hard_stop,
  input  logic             line_complete
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_FIRE,
    S_WAIT,
    S_CLEAR,
    S_STOP
  } state_e;

  localparam logic [AW:0] DEPTH_N = (AW + 1)'(DEPTH);

  state_e           state, state_d;
  logic [AW-1:0]    idx_d;
  logic [AW:0]      num_q, num_d;
  logic [AW:0]      num_clamped;
  logic             last_step;
  logic             done_d;
  logic             busy_d, mark_d, go_d, lrst_d, hs_d;
  logic [DEL_W-1:0] delay_d;
  logic [DUR_W-1:0] duration_d;

`ifdef SEQ_LOOP_EN
  logic [7:0]       loops_q, loops_d;
`endif

  logic [DEL_W-1:0] del_mem [DEPTH];
  logic [DUR_W-1:0] dur_mem [DEPTH];

  // NOTE: the step table has no reset; its contents must survive rst, and
  // leaving it out of the reset branch keeps it plain storage.
  always_ff @(posedge clk) begin
    if (wr_en && !busy) begin
      del_mem[wr_addr] <= wr_delay;
      dur_mem[wr_addr] <= wr_duration;
    end
  end

  assign num_clamped = (num_steps > DEPTH_N) ? DEPTH_N : num_steps;
  assign last_step   = ({1'b0, step_idx} == (num_q - (AW + 1)'(1)));

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_IDLE;
      step_idx <= '0;
      num_q    <= '0;
`ifdef SEQ_LOOP_EN
      loops_q  <= '0;
`endif
    end else begin
      state    <= state_d;
      step_idx <= idx_d;
      num_q    <= num_d;
`ifdef SEQ_LOOP_EN
      loops_q  <= loops_d;
`endif
    end
  end

  // NOTE: every variable gets a default at the top of a combinational block,
  // so no path through the case statement can infer a latch.
  always_comb begin
    state_d = state;
    idx_d   = step_idx;
    num_d   = num_q;
    done_d  = 1'b0;
`ifdef SEQ_LOOP_EN
    loops_d = loops_q;
`endif
    if ((state != S_IDLE) && abort) begin
      state_d = S_STOP;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            if (num_steps == '0) begin
              done_d = 1'b1;
            end else begin
              num_d   = num_clamped;
              idx_d   = '0;
              state_d = S_ARM;
`ifdef SEQ_LOOP_EN
              loops_d = loop_count;
`endif
            end
          end
        end
        S_ARM:  state_d = S_FIRE;
        S_FIRE: state_d = S_WAIT;
        S_WAIT: begin
          if (line_complete) state_d = S_CLEAR;
        end
        S_CLEAR: begin
          if (last_step) begin
`ifdef SEQ_LOOP_EN
            if (loops_q != 8'd0) begin
              loops_d = loops_q - 8'd1;
              idx_d   = '0;
              state_d = S_ARM;
            end else begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end
`else
            state_d = S_IDLE;
            done_d  = 1'b1;
`endif
          end else begin
            idx_d   = step_idx + AW'(1);
            state_d = S_ARM;
          end
        end
        S_STOP:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs decode the next state so they can be registered without adding a cycle.
  always_comb begin
    busy_d     = (state_d != S_IDLE);
    mark_d     = (state_d == S_ARM) || (state_d == S_FIRE);
    go_d       = (state_d == S_FIRE);
    lrst_d     = (state_d == S_CLEAR) || (state_d == S_STOP);
    hs_d       = (state_d == S_STOP);
    delay_d    = line_delay;
    duration_d = line_duration;
    if (state_d == S_ARM) begin
      delay_d    = del_mem[idx_d];
      duration_d = dur_mem[idx_d];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      busy           <= 1'b0;
      done           <= 1'b0;
      line_mark      <= 1'b0;
      line_go        <= 1'b0;
      line_rst       <= 1'b1;
      line_hard_stop <= 1'b0;
      line_delay     <= '0;
      line_duration  <= '0;
    end else begin
      busy           <= busy_d;
      done           <= done_d;
      line_mark      <= mark_d;
      line_go        <= go_d;
      line_rst       <= lrst_d;
      line_hard_stop <= hs_d;
      line_delay     <= delay_d;
      line_duration  <= duration_d;
    end
  end

  // Invariants of the output encoding.
  a_go_has_mark: assert property (@(posedge clk) disable iff (!rst) line_go |-> line_mark);
  a_done_idle:   assert property (@(posedge clk) disable iff (!rst) done |-> !busy);
  a_stop_clears: assert property (@(posedge clk) disable iff (!rst) line_hard_stop |-> line_rst);
  a_idx_range:   assert property (@(posedge clk) disable iff (!rst) busy |-> ({1'b0, step_idx} < num_q));

endmodule

// File: tb/tb_io_line_step_sequencer.sv
// Randomised bench for io_line_step_sequencer: expected cycle traces are built from the step table.
// A stand-in line controller answers each FIRE with outputComplete after delay+duration cycles.
module tb_io_line_step_sequencer;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int DUR_W = 11;
  localparam int DEL_W = 21;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             wr_en = 1'b0;
  logic [AW-1:0]    wr_addr = '0;
  logic [DEL_W-1:0] wr_delay = '0;
  logic [DUR_W-1:0] wr_duration = '0;
  logic [AW:0]      num_steps = '0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
`ifdef SEQ_LOOP_EN
  logic [7:0]       loop_count = '0;
`endif
  logic             busy, done, line_mark, line_go, line_rst, line_hard_stop;
  logic [AW-1:0]    step_idx;
  logic [DEL_W-1:0] line_delay;
  logic [DUR_W-1:0] line_duration;
  logic             line_complete = 1'b0;

  io_line_step_sequencer #(.DEPTH(DEPTH), .AW(AW), .DUR_W(DUR_W), .DEL_W(DEL_W)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_delay(wr_delay),
    .wr_duration(wr_duration), .num_steps(num_steps), .start(start), .abort(abort),
`ifdef SEQ_LOOP_EN
    .loop_count(loop_count),
`endif
    .busy(busy), .done(done), .step_idx(step_idx), .line_mark(line_mark), .line_go(line_go),
    .line_delay(line_delay), .line_duration(line_duration), .line_rst(line_rst),
    .line_hard_stop(line_hard_stop), .line_complete(line_complete)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             busy;
    logic             done;
    logic             mark;
    logic             go;
    logic             lrst;
    logic             hs;
    logic [AW-1:0]    idx;
    logic [DEL_W-1:0] dly;
    logic [DUR_W-1:0] dur;
  } obs_t;

  typedef struct {
    obs_t v;
    bit   care;
  } exp_t;

  exp_t             exp_q[$];
  int               total = 0;
  int               bad = 0;
  logic [DEL_W-1:0] m_dly [DEPTH];
  logic [DUR_W-1:0] m_dur [DEPTH];
  int               last_idx = 0;
  bit               noise = 1'b0;

  // Controller stand-in latency, capped so wide table values stay quick to play.
  function automatic int ctrl_lat(logic [DEL_W-1:0] d, logic [DUR_W-1:0] u);
    int s;
    s = int'(d) + int'(u);
    return (s > 40) ? 40 : s;
  endfunction

  initial begin : ctrl_stub
    int cnt;
    bit waiting;
    cnt = 0;
    waiting = 1'b0;
    forever begin
      @(negedge clk);
      if (line_rst) begin
        line_complete = 1'b0;
        waiting = 1'b0;
      end else if (line_go) begin
        cnt = ctrl_lat(line_delay, line_duration);
        waiting = 1'b1;
        line_complete = noise;
      end else if (line_mark) begin
        line_complete = noise;
      end else if (waiting) begin
        if (cnt == 0) line_complete = 1'b1;
        else begin
          cnt--;
          line_complete = 1'b0;
        end
      end else begin
        line_complete = 1'b0;
      end
    end
  end

  function automatic obs_t sample();
    obs_t o;
    o.busy = busy; o.done = done; o.mark = line_mark; o.go = line_go;
    o.lrst = line_rst; o.hs = line_hard_stop; o.idx = step_idx;
    o.dly = line_delay; o.dur = line_duration;
    return o;
  endfunction

  function automatic string fmt(obs_t o);
    return $sformatf("busy=%b done=%b mark=%b go=%b lrst=%b hs=%b idx=%0d dly=%0d dur=%0d",
                     o.busy, o.done, o.mark, o.go, o.lrst, o.hs, o.idx, o.dly, o.dur);
  endfunction

  task automatic push(bit b, bit d, bit m, bit g, bit lr, bit h, int idx, int k, bit care);
    exp_t e;
    e.v.busy = b; e.v.done = d; e.v.mark = m; e.v.go = g; e.v.lrst = lr; e.v.hs = h;
    e.v.idx  = idx[AW-1:0];
    e.v.dly  = care ? m_dly[k] : '0;
    e.v.dur  = care ? m_dur[k] : '0;
    e.care   = care;
    exp_q.push_back(e);
  endtask

  // Per step: ARM, FIRE, (latency+1) WAIT cycles, CLEAR; then one done cycle in IDLE.
  task automatic build_trace(int num, int loops, bit tail);
    int n;
    n = (num > DEPTH) ? DEPTH : num;
    if (n == 0) begin
      push(0, 1, 0, 0, 0, 0, last_idx, 0, 0);
      if (tail) push(0, 0, 0, 0, 0, 0, last_idx, 0, 0);
    end else begin
      for (int p = 0; p <= loops; p++) begin
        for (int k = 0; k < n; k++) begin
          push(1, 0, 1, 0, 0, 0, k, k, 1);
          push(1, 0, 1, 1, 0, 0, k, k, 1);
          repeat (ctrl_lat(m_dly[k], m_dur[k]) + 1) push(1, 0, 0, 0, 0, 0, k, k, 1);
          push(1, 0, 0, 0, 1, 0, k, k, 1);
        end
      end
      push(0, 1, 0, 0, 0, 0, n - 1, n - 1, 1);
      if (tail) push(0, 0, 0, 0, 0, 0, n - 1, n - 1, 1);
      last_idx = n - 1;
    end
  endtask

  task automatic check_trace(string name, int drop_at, bit wr_noise);
    int i;
    i = 0;
    while (exp_q.size() > 0) begin
      exp_t e;
      obs_t o;
      e = exp_q.pop_front();
      @(negedge clk);
      o = sample();
      if (!e.care) begin
        o.dly = '0;
        o.dur = '0;
      end
      total++;
      if (o !== e.v) begin
        bad++;
        $display("FAIL %s cyc=%0d got {%s} exp {%s}", name, i, fmt(o), fmt(e.v));
      end
      if (i == drop_at) begin
        start = 1'b0;
        abort = 1'b0;
      end
      wr_en = wr_noise && e.v.busy;
      wr_addr = AW'($urandom);
      wr_delay = DEL_W'($urandom);
      wr_duration = DUR_W'($urandom);
      i++;
    end
    wr_en = 1'b0;
  endtask

  task automatic write_entry(int a, int d, int u);
    @(negedge clk);
    wr_en = 1'b1;
    wr_addr = a[AW-1:0];
    wr_delay = d[DEL_W-1:0];
    wr_duration = u[DUR_W-1:0];
    m_dly[a] = d[DEL_W-1:0];
    m_dur[a] = u[DUR_W-1:0];
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic write_random_table();
    for (int a = 0; a < DEPTH; a++) write_entry(a, $urandom_range(0, 6), $urandom_range(0, 5));
  endtask

  task automatic run_program(string name, int num, int loops, bit nz, bit wrn);
    @(negedge clk);
    num_steps = num[AW:0];
`ifdef SEQ_LOOP_EN
    loop_count = loops[7:0];
`endif
    noise = nz;
    build_trace(num, loops, 1);
    start = 1'b1;
    check_trace(name, 0, wrn);
    noise = 1'b0;
  endtask

  task automatic test_reset();
    obs_t o, e;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    e = '0;
    e.lrst = 1'b1;
    o = sample();
    total++;
    if (o !== e) begin
      bad++;
      $display("FAIL reset_hold got {%s} exp {%s}", fmt(o), fmt(e));
    end
    rst = 1'b1;
    @(negedge clk);
    e.lrst = 1'b0;
    o = sample();
    total++;
    if (o !== e) begin
      bad++;
      $display("FAIL reset_release got {%s} exp {%s}", fmt(o), fmt(e));
    end
    last_idx = 0;
  endtask

  task automatic test_single_step();
    write_entry(0, 5, 4);
    run_program("single_step", 1, 0, 0, 0);
  endtask

  task automatic test_three_steps();
    write_entry(0, 0, 1);
    write_entry(1, 2, 3);
    write_entry(2, 10, 0);
    run_program("three_steps", 3, 0, 1, 0);
  endtask

  task automatic test_edges();
    run_program("zero_steps", 0, 0, 0, 0);
    // abort while idle must leave every output quiet
    @(negedge clk);
    abort = 1'b1;
    push(0, 0, 0, 0, 0, 0, last_idx, 0, 0);
    push(0, 0, 0, 0, 0, 0, last_idx, 0, 0);
    check_trace("idle_abort", 0, 0);
    write_random_table();
    run_program("clamp_15", 15, 0, 0, 0);
    run_program("full_depth", DEPTH, 0, 1, 0);
  endtask

  task automatic test_busy_writes();
    write_random_table();
    run_program("busy_writes", DEPTH, 0, 0, 1);
    run_program("readback", DEPTH, 0, 0, 0);
  endtask

  task automatic test_start_held();
    int first_len;
    @(negedge clk);
    num_steps = 2;
    build_trace(2, 0, 0);
    first_len = exp_q.size();
    build_trace(2, 0, 1);
    start = 1'b1;
    check_trace("start_held", first_len, 0);
  endtask

  task automatic test_abort();
    bit saw_mark, saw_done;
    write_entry(0, 2, 1);
    write_entry(1, 100, 3);
    write_entry(2, 1, 1);
    @(negedge clk);
    num_steps = 3;
    for (int k = 0; k < 2; k++) begin
      push(1, 0, 1, 0, 0, 0, k, k, 1);
      push(1, 0, 1, 1, 0, 0, k, k, 1);
      if (k == 0) begin
        repeat (ctrl_lat(m_dly[0], m_dur[0]) + 1) push(1, 0, 0, 0, 0, 0, 0, 0, 1);
        push(1, 0, 0, 0, 1, 0, 0, 0, 1);
      end else begin
        repeat (20) push(1, 0, 0, 0, 0, 0, 1, 1, 1);
      end
    end
    start = 1'b1;
    check_trace("abort_pre", 0, 0);
    abort = 1'b1;
    push(1, 0, 0, 0, 1, 1, 1, 1, 1);
    push(0, 0, 0, 0, 0, 0, 1, 1, 1);
    check_trace("abort_stop", 0, 0);
    last_idx = 1;
    saw_mark = 1'b0;
    saw_done = 1'b0;
    repeat (120) begin
      @(negedge clk);
      if (line_mark) saw_mark = 1'b1;
      if (done) saw_done = 1'b1;
    end
    total++;
    if (saw_mark) begin
      bad++;
      $display("FAIL abort_no_rearm got mark=%b exp mark=0", saw_mark);
    end
    total++;
    if (saw_done) begin
      bad++;
      $display("FAIL abort_no_done got done=%b exp done=0", saw_done);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 12; r++) begin
      write_random_table();
      run_program($sformatf("random_%0d", r), $urandom_range(0, 15), 0,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_table_survives_reset();
    test_reset();
    run_program("after_reset", DEPTH, 0, 0, 0);
  endtask

  task automatic test_wide_values();
    write_entry(0, 21'h1FFFFF, 11'h7FF);
    write_entry(1, 21'h155555, 11'h2AA);
    run_program("wide_values", 2, 0, 0, 0);
  endtask

`ifdef SEQ_LOOP_EN
  task automatic test_loop();
    write_random_table();
    run_program("loop_2x2", 2, 2, 0, 0);
    run_program("loop_zero", 3, 0, 0, 0);
  endtask
`endif

  initial begin
    test_reset();
    test_single_step();
    test_three_steps();
    test_edges();
    test_busy_writes();
    test_start_held();
    test_abort();
    test_random();
    test_table_survives_reset();
    test_wide_values();
`ifdef SEQ_LOOP_EN
    test_loop();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
